test_fast_dram_axi_traffic_master: RTL and testbench

//  AXI4 initiator (traffic generator/checker) for the test_fast_dram platform; drives the SRAM/DRAM AXI slave ports.
//  On start: writes NUM_BURST INCR bursts of a seeded pattern from BASEADDR, reads them back, compares, reports pass/fail.
//  One transaction outstanding at a time; all data beats are full-width; self-checking bring-up and regression agent.

---
 rtl/test_fast_dram_axi_traffic_master_if.sv | 77 +++++++
 rtl/test_fast_dram_axi_traffic_master.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_test_fast_dram_axi_traffic_master.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_fast_dram_axi_traffic_master_if.sv
// AXI4 bus bundle between the test_fast_dram traffic master and an SRAM/DRAM slave.
//
// Parameters: BW_ADDR (address width), BW_DATA (data width), BW_AXI_TID (ID width).
// Modports:
//   master - drives AW/W/AR payload and valids, B/R readies; samples the rest.
//   slave  - the mirror image, used by slave models.
//
// Handshake semantics (all five channels): a transfer happens on the rising
// clk edge where valid and ready are both 1. Once valid is raised it stays high,
// with its payload unchanged, until that edge. valid never depends
// combinationally on ready. ready may be raised or lowered at any time.
interface test_fast_dram_axi_traffic_master_if #(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 128,
    parameter int BW_AXI_TID = 4
);
    logic [BW_AXI_TID-1:0] txawid;
    logic [BW_ADDR-1:0]    txawaddr;
    logic [7:0]            txawlen;
    logic [2:0]            txawsize;
    logic [1:0]            txawburst;
    logic                  txawvalid;
    logic                  txawready;

    logic [BW_AXI_TID-1:0] txarid;
    logic [BW_ADDR-1:0]    txaraddr;
    logic [7:0]            txarlen;
    logic [2:0]            txarsize;
    logic [1:0]            txarburst;
    logic                  txarvalid;
    logic                  txarready;

    logic [BW_AXI_TID-1:0] txwid;
    logic [BW_DATA-1:0]    txwdata;
    logic [BW_DATA/8-1:0]  txwstrb;
    logic                  txwlast;
    logic                  txwvalid;
    logic                  txwready;

    logic [BW_AXI_TID-1:0] txbid;
    logic [1:0]            txbresp;
    logic                  txbvalid;
    logic                  txbready;

    logic [BW_AXI_TID-1:0] txrid;
    logic [BW_DATA-1:0]    txrdata;
    logic [1:0]            txrresp;
    logic                  txrlast;
    logic                  txrvalid;
    logic                  txrready;

    modport master (
        output txawid, txawaddr, txawlen, txawsize, txawburst, txawvalid,
        input  txawready,
        output txarid, txaraddr, txarlen, txarsize, txarburst, txarvalid,
        input  txarready,
        output txwid, txwdata, txwstrb, txwlast, txwvalid,
        input  txwready,
        input  txbid, txbresp, txbvalid,
        output txbready,
        input  txrid, txrdata, txrresp, txrlast, txrvalid,
        output txrready
    );

    modport slave (
        input  txawid, txawaddr, txawlen, txawsize, txawburst, txawvalid,
        output txawready,
        input  txarid, txaraddr, txarlen, txarsize, txarburst, txarvalid,
        output txarready,
        input  txwid, txwdata, txwstrb, txwlast, txwvalid,
        output txwready,
        output txbid, txbresp, txbvalid,
        input  txbready,
        output txrid, txrdata, txrresp, txrlast, txrvalid,
        input  txrready
    );
endinterface

// File: rtl/test_fast_dram_axi_traffic_master.sv
// AXI4 traffic generator/checker for the test_fast_dram platform.
//
// A start pulse (accepted only when idle) writes NUM_BURST INCR bursts of a
// seeded counting pattern starting at BASEADDR, reads them back, and compares.
// Only one transaction is outstanding at any time.
//
// Ports:
//   clk, rstnn      clock, synchronous active-low reset
//   start, seed     begin a pass; seed sampled on the accepted start
//   busy            pass running
//   done, pass      pass finished (held until next start); done with no errors
//   err_count       bad bresp/rresp, data mismatches and wrong rlast (saturating)
//   dbg_state       current FSM state encoding
//   axi             master side of the AXI4 bundle
//
// Optional feature: define TEST_FAST_DRAM_FIRST_ERR_EN to add first_err_addr /
// first_err_data, which capture the beat address and read data of the first
// failing read beat of a pass.
module test_fast_dram_axi_traffic_master #(
    parameter int                 BW_ADDR    = 32,
    parameter int                 BW_DATA    = 128,
    parameter int                 BW_AXI_TID = 4,
    parameter logic [BW_ADDR-1:0] BASEADDR   = '0,
    parameter int                 NUM_BURST  = 16,
    parameter int                 BURST_LEN  = 8
) (
    input  logic        clk,
    input  logic        rstnn,
    input  logic        start,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [2:0]  dbg_state,
`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
    output logic [BW_ADDR-1:0] first_err_addr,
    output logic [BW_DATA-1:0] first_err_data,
`endif
    test_fast_dram_axi_traffic_master_if.master axi
);
    localparam int                 LANES       = BW_DATA / 32;
    localparam int                 BEAT_BYTES  = BW_DATA / 8;
    localparam int                 SIZE        = $clog2(BEAT_BYTES);
    localparam logic [BW_ADDR-1:0] BURST_BYTES = BW_ADDR'(BURST_LEN * BEAT_BYTES);
    localparam logic [7:0]         LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [15:0]        LAST_BURST  = 16'(NUM_BURST - 1);
    localparam logic [31:0]        LANE_STEP   = 32'(LANES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_FIN  = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          burst_q, burst_d;
    logic [7:0]           beat_q, beat_d;
    logic [BW_ADDR-1:0]   addr_q, addr_d;
    logic [31:0]          pat_q, pat_d;     // lane-0 value of the current beat
    logic [31:0]          seed_q, seed_d;
    logic [15:0]          err_q, err_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 wlast_q, wlast_d;
    logic                 bready_q, bready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
    logic                 fe_seen_q, fe_seen_d;
    logic [BW_ADDR-1:0]   fe_addr_q, fe_addr_d;
    logic [BW_DATA-1:0]   fe_data_q, fe_data_d;
`endif

    logic                 last_beat;
    logic                 last_burst;
    logic [BW_DATA-1:0]   beat_data;
    logic                 r_resp_bad, r_data_bad, r_last_bad;
    logic [1:0]           err_inc;
    logic [16:0]          err_sum;
    logic                 err_clr;
    logic                 rd_bad;
    logic                 unused_ids;

    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == LAST_BURST);

    // Expected/written beat: lane j = pat + j. pat_q only moves on a
    // completed beat, so txwdata stays stable while W is stalled.
    always_comb begin
        beat_data = '0;
        for (int j = 0; j < LANES; j++) begin
            beat_data[j*32 +: 32] = pat_q + 32'(j);
        end
    end

    assign r_resp_bad = (axi.txrresp != 2'b00);
    assign r_data_bad = (axi.txrdata != beat_data);
    assign r_last_bad = (axi.txrlast != last_beat);

    // State register and all other flops.
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state_q   <= ST_IDLE;
            burst_q   <= '0;
            beat_q    <= '0;
            addr_q    <= '0;
            pat_q     <= '0;
            seed_q    <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
            fe_seen_q <= 1'b0;
            fe_addr_q <= '0;
            fe_data_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            pat_q     <= pat_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
            fe_seen_q <= fe_seen_d;
            fe_addr_q <= fe_addr_d;
            fe_data_q <= fe_data_d;
`endif
        end
    end

    // Next-state logic. Valids/readies are constant within a state, so the
    // handshake conditions only need the slave-side signal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_AW;
            ST_AW:   if (axi.txawready) state_d = ST_W;
            ST_W:    if (axi.txwready && last_beat) state_d = ST_B;
            ST_B:    if (axi.txbvalid) state_d = last_burst ? ST_AR : ST_AW;
            ST_AR:   if (axi.txarready) state_d = ST_R;
            // Leave R on the beat count, never on rlast, so a slave with a
            // broken rlast cannot hang the pass.
            ST_R:    if (axi.txrvalid && last_beat) state_d = last_burst ? ST_FIN : ST_AR;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, checks and registered outputs.
    always_comb begin
        burst_d = burst_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        pat_d   = pat_q;
        seed_d  = seed_q;
        done_d  = done_q;
        err_inc = 2'd0;
        err_clr = 1'b0;
        rd_bad  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    burst_d = '0;
                    beat_d  = '0;
                    addr_d  = BASEADDR;
                    pat_d   = seed;
                    seed_d  = seed;
                    done_d  = 1'b0;
                    err_clr = 1'b1;
                end
            end
            ST_W: begin
                if (axi.txwready) begin
                    pat_d  = pat_q + LANE_STEP;
                    beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
                end
            end
            ST_B: begin
                if (axi.txbvalid) begin
                    err_inc = {1'b0, axi.txbresp != 2'b00};
                    if (last_burst) begin
                        // Rewind to the first burst for the read-back phase.
                        burst_d = '0;
                        addr_d  = BASEADDR;
                        pat_d   = seed_q;
                    end else begin
                        burst_d = burst_q + 16'd1;
                        addr_d  = addr_q + BURST_BYTES;
                    end
                end
            end
            ST_R: begin
                if (axi.txrvalid) begin
                    err_inc = {1'b0, r_resp_bad} + {1'b0, r_data_bad} + {1'b0, r_last_bad};
                    rd_bad  = r_resp_bad | r_data_bad | r_last_bad;
                    pat_d   = pat_q + LANE_STEP;
                    beat_d  = last_beat ? 8'd0 : beat_q + 8'd1;
                    if (last_beat && !last_burst) begin
                        burst_d = burst_q + 16'd1;
                        addr_d  = addr_q + BURST_BYTES;
                    end
                end
            end
            ST_FIN: done_d = 1'b1;
            default: ;
        endcase

        err_sum = {1'b0, err_q} + {15'd0, err_inc};
        if (err_clr) begin
            err_d = '0;
        end else begin
            err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end

        // Decoded from the next state so each valid is a flop that rises on
        // the first cycle of its state.
        busy_d    = (state_d != ST_IDLE);
        awvalid_d = (state_d == ST_AW);
        wvalid_d  = (state_d == ST_W);
        wlast_d   = (state_d == ST_W) && (beat_d == LAST_BEAT);
        bready_d  = (state_d == ST_B);
        arvalid_d = (state_d == ST_AR);
        rready_d  = (state_d == ST_R);

`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
        fe_seen_d = fe_seen_q;
        fe_addr_d = fe_addr_q;
        fe_data_d = fe_data_q;
        if (err_clr) begin
            fe_seen_d = 1'b0;
            fe_addr_d = '0;
            fe_data_d = '0;
        end else if (rd_bad && !fe_seen_q) begin
            fe_seen_d = 1'b1;
            fe_addr_d = addr_q + (BW_ADDR'(beat_q) << SIZE);
            fe_data_d = axi.txrdata;
        end
`endif
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = done_q && (err_q == 16'd0);
    assign err_count = err_q;
    assign dbg_state = state_q;
`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
    assign first_err_addr = fe_addr_q;
    assign first_err_data = fe_data_q;
`endif

    assign axi.txawid    = {BW_AXI_TID{1'b0}};
    assign axi.txawaddr  = addr_q;
    assign axi.txawlen   = LAST_BEAT;
    assign axi.txawsize  = 3'(SIZE);
    assign axi.txawburst = 2'b01;
    assign axi.txawvalid = awvalid_q;

    assign axi.txarid    = {BW_AXI_TID{1'b0}};
    assign axi.txaraddr  = addr_q;
    assign axi.txarlen   = LAST_BEAT;
    assign axi.txarsize  = 3'(SIZE);
    assign axi.txarburst = 2'b01;
    assign axi.txarvalid = arvalid_q;

    assign axi.txwid     = {BW_AXI_TID{1'b0}};
    assign axi.txwdata   = beat_data;
    assign axi.txwstrb   = '1;
    assign axi.txwlast   = wlast_q;
    assign axi.txwvalid  = wvalid_q;

    assign axi.txbready  = bready_q;
    assign axi.txrready  = rready_q;

    // Response IDs carry no information with a single outstanding transaction.
    assign unused_ids = ^{axi.txbid, axi.txrid};
endmodule

// File: tb/tb_test_fast_dram_axi_traffic_master.sv
module tb_test_fast_dram_axi_traffic_master;
    localparam int          BW_ADDR    = 32;
    localparam int          BW_DATA    = 128;
    localparam int          BW_AXI_TID = 4;
    localparam int          NUM_BURST  = 16;
    localparam int          BURST_LEN  = 8;
    localparam logic [31:0] BASE       = 32'h0;
    localparam int          LANES      = BW_DATA / 32;
    localparam int          BEAT_BYTES = BW_DATA / 8;
    localparam int          BUDGET     = 20000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rstnn;
    logic        start;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [2:0]  dbg_state;
`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
    logic [BW_ADDR-1:0] first_err_addr;
    logic [BW_DATA-1:0] first_err_data;
`endif

    always #5 clk = ~clk;

    test_fast_dram_axi_traffic_master_if #(
        .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_AXI_TID(BW_AXI_TID)
    ) axi ();

    test_fast_dram_axi_traffic_master #(
        .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_AXI_TID(BW_AXI_TID),
        .BASEADDR(BASE), .NUM_BURST(NUM_BURST), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk       (clk),
        .rstnn     (rstnn),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .dbg_state (dbg_state),
`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
`endif
        .axi       (axi)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [BW_ADDR-1:0] exp_q[$];     // expected AW addresses, in order
    logic [BW_ADDR-1:0] exp_ar_q[$];  // expected AR addresses, in order

    // fault/backpressure knobs for the slave model
    int          stall_pct        = 0;
    int          corrupt_n        = -1;
    int          bad_b_burst      = -1;
    int          drop_rlast_burst = -1;
    logic [31:0] cur_seed         = 32'h0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference pattern: lane j of global beat n = seed + n*LANES + j.
    function automatic logic [BW_DATA-1:0] pattern(input logic [31:0] s, input int n);
        logic [BW_DATA-1:0] d;
        d = '0;
        for (int j = 0; j < LANES; j++) d[j*32 +: 32] = s + 32'(n * LANES + j);
        return d;
    endfunction

    function automatic bit rnd_go();
        return $urandom_range(99) >= stall_pct;
    endfunction

    // ---------------- slave model (drives on negedge) ----------------
    logic [BW_DATA-1:0] mem [logic [BW_ADDR-1:0]];
    int aw_cnt = 0, ar_cnt = 0, w_beats = 0, b_cnt = 0, r_beats = 0;
    int w_beat = 0, r_beat = 0, b_pend = 0, r_burst = 0;
    bit r_active = 0, r_fired = 0, b_fired = 0;
    logic [BW_ADDR-1:0] w_addr = '0, r_addr = '0;
    bit p_aw = 0, p_w = 0, p_ar = 0;
    logic [BW_ADDR-1:0] p_awaddr = '0, p_araddr = '0;
    logic [BW_DATA-1:0] p_wdata = '0;
    logic               p_wlast = 1'b0;

    always @(negedge clk) begin
        logic [BW_DATA-1:0] d;
        if (!rstnn) begin
            axi.txawready = 1'b0; axi.txwready = 1'b0; axi.txarready = 1'b0;
            axi.txbvalid = 1'b0; axi.txbresp = 2'b00; axi.txbid = '0;
            axi.txrvalid = 1'b0; axi.txrresp = 2'b00; axi.txrid = '0;
            axi.txrdata = '0; axi.txrlast = 1'b0;
            r_active = 0; r_fired = 0; b_fired = 0; b_pend = 0;
            w_beat = 0; r_beat = 0; p_aw = 0; p_w = 0; p_ar = 0;
        end else begin
            if (start && !busy) begin
                aw_cnt = 0; ar_cnt = 0; w_beats = 0; b_cnt = 0; r_beats = 0;
                w_beat = 0; r_beat = 0; b_pend = 0; r_active = 0;
            end
            // a stalled valid must still be there with the same payload
            if (p_aw) begin
                check("aw_hold_valid", axi.txawvalid, 1'b1);
                check("aw_hold_addr", axi.txawaddr, p_awaddr);
            end
            if (p_w) begin
                check("w_hold_valid", axi.txwvalid, 1'b1);
                check("w_hold_data", axi.txwdata, p_wdata);
                check("w_hold_last", axi.txwlast, p_wlast);
            end
            if (p_ar) begin
                check("ar_hold_valid", axi.txarvalid, 1'b1);
                check("ar_hold_addr", axi.txaraddr, p_araddr);
            end
            p_aw = 0; p_w = 0; p_ar = 0;

            // B channel
            if (b_fired) begin axi.txbvalid = 1'b0; b_fired = 0; end
            if (!axi.txbvalid && b_pend > 0 && rnd_go()) begin
                axi.txbvalid = 1'b1;
                axi.txbresp  = (b_cnt == bad_b_burst) ? 2'b10 : 2'b00;
            end
            if (axi.txbvalid && axi.txbready) begin
                b_fired = 1; b_pend--; b_cnt++;
            end

            // R channel
            if (r_fired) begin axi.txrvalid = 1'b0; r_fired = 0; end
            if (!axi.txrvalid && r_active && rnd_go()) begin
                logic [BW_ADDR-1:0] a;
                a = r_addr + 32'(r_beat * BEAT_BYTES);
                d = mem.exists(a) ? mem[a] : '0;
                if (r_beats == corrupt_n) d[0] = ~d[0];
                axi.txrdata  = d;
                axi.txrresp  = 2'b00;
                axi.txrlast  = (r_beat == BURST_LEN - 1) && (r_burst != drop_rlast_burst);
                axi.txrvalid = 1'b1;
            end
            if (axi.txrvalid && axi.txrready) begin
                r_fired = 1; r_beats++; r_beat++;
                if (r_beat == BURST_LEN) begin r_beat = 0; r_active = 0; end
            end

            // AW channel
            axi.txawready = rnd_go();
            if (axi.txawvalid && axi.txawready) begin
                if (exp_q.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
                else check("aw_addr", axi.txawaddr, exp_q.pop_front());
                check("aw_fmt", {axi.txawlen, axi.txawsize, axi.txawburst, axi.txawid},
                      {8'(BURST_LEN - 1), 3'd4, 2'b01, 4'd0});
                w_addr = axi.txawaddr; aw_cnt++;
            end else if (axi.txawvalid) begin
                p_aw = 1; p_awaddr = axi.txawaddr;
            end

            // W channel
            axi.txwready = rnd_go();
            if (axi.txwvalid && axi.txwready) begin
                check("w_data", axi.txwdata, pattern(cur_seed, w_beats));
                check("w_last", axi.txwlast, (w_beat == BURST_LEN - 1));
                check("w_strb", axi.txwstrb, 16'hFFFF);
                mem[w_addr + 32'(w_beat * BEAT_BYTES)] = axi.txwdata;
                w_beats++; w_beat++;
                if (w_beat == BURST_LEN) begin w_beat = 0; b_pend++; end
            end else if (axi.txwvalid) begin
                p_w = 1; p_wdata = axi.txwdata; p_wlast = axi.txwlast;
            end

            // AR channel
            axi.txarready = rnd_go();
            if (axi.txarvalid && axi.txarready) begin
                if (exp_ar_q.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
                else check("ar_addr", axi.txaraddr, exp_ar_q.pop_front());
                check("ar_fmt", {axi.txarlen, axi.txarsize, axi.txarburst, axi.txarid},
                      {8'(BURST_LEN - 1), 3'd4, 2'b01, 4'd0});
                r_addr = axi.txaraddr; r_beat = 0; r_active = 1; r_burst = ar_cnt; ar_cnt++;
            end else if (axi.txarvalid) begin
                p_ar = 1; p_araddr = axi.txaraddr;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_err"}, err_count, 16'd0);
        check({tag, "_valids"},
              {axi.txawvalid, axi.txwvalid, axi.txwlast, axi.txarvalid, axi.txbready, axi.txrready},
              6'b0);
    endtask

    task automatic arm_pass(input logic [31:0] s, input int stall, input int cn,
                            input int bb, input int dr);
        exp_q.delete();
        exp_ar_q.delete();
        for (int k = 0; k < NUM_BURST; k++) begin
            exp_q.push_back(BASE + 32'(k * BURST_LEN * BEAT_BYTES));
            exp_ar_q.push_back(BASE + 32'(k * BURST_LEN * BEAT_BYTES));
        end
        stall_pct = stall; corrupt_n = cn; bad_b_burst = bb; drop_rlast_burst = dr;
        cur_seed = s;
        seed = s; start = 1'b1;
        tick();
        start = 1'b0;
        seed = $urandom();
        check("start_busy", busy, 1'b1);
        check("start_awvalid", axi.txawvalid, 1'b1);
        check("start_done_clr", done, 1'b0);
        check("start_err_clr", err_count, 16'd0);
    endtask

    task automatic run_pass(input logic [31:0] s, input int stall, input int cn,
                            input int bb, input int dr, input bit mid_start);
        int cyc;
        int exp_err;
`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
        int fidx;
        logic [BW_DATA-1:0] fdata;
`endif
        exp_err = int'(cn >= 0) + int'(bb >= 0) + int'(dr >= 0);
        arm_pass(s, stall, cn, bb, dr);
        cyc = 0;
        while (!done && cyc < BUDGET) begin
            if (mid_start && cyc == 50) begin
                start = 1'b1;
                seed = $urandom();
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check("pass_in_budget", cyc < BUDGET, 1'b1);
        check("end_done", done, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_err_count", err_count, 16'(exp_err));
        check("end_pass", pass, exp_err == 0);
        check("aw_count", aw_cnt, NUM_BURST);
        check("ar_count", ar_cnt, NUM_BURST);
        check("w_beat_count", w_beats, NUM_BURST * BURST_LEN);
        check("r_beat_count", r_beats, NUM_BURST * BURST_LEN);
`ifdef TEST_FAST_DRAM_FIRST_ERR_EN
        fidx = cn;
        if (dr >= 0 && (fidx < 0 || dr * BURST_LEN + BURST_LEN - 1 < fidx))
            fidx = dr * BURST_LEN + BURST_LEN - 1;
        if (fidx >= 0) begin
            fdata = pattern(s, fidx);
            if (fidx == cn) fdata[0] = ~fdata[0];
            check("first_err_addr", first_err_addr, BASE + 32'(fidx * BEAT_BYTES));
            check("first_err_data", first_err_data, fdata);
        end else begin
            check("first_err_addr_none", first_err_addr, 32'h0);
            check("first_err_data_none", first_err_data, 128'h0);
        end
`endif
        tick();
        check("done_held", done, 1'b1);
    endtask

    task automatic reset_mid_read();
        int cyc;
        arm_pass($urandom(), 30, -1, -1, -1);
        cyc = 0;
        while (!(ar_cnt == 10 && axi.txrready) && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        check("mid_read_reached", cyc < BUDGET, 1'b1);
        rstnn = 1'b0;
        tick();
        check_reset_state("mid_rst");
        rstnn = 1'b1;
        tick();
        check_reset_state("post_rst");
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        int cn, bb, dr;
        rstnn = 1'b0;
        start = 1'b0;
        seed  = 32'h0;
        repeat (3) tick();
        check_reset_state("por");
        rstnn = 1'b1;
        tick();

        run_pass(32'h0, 0, -1, -1, -1, 0);        // zero-wait slave, seed 0
        run_pass($urandom(), 50, -1, -1, -1, 0);  // 50% backpressure everywhere
        run_pass(32'h0, 0, 5, -1, -1, 0);         // bit 0 of read beat 5 flipped
        run_pass($urandom(), 30, -1, 3, 7, 0);    // bad bresp burst 3, no rlast burst 7
        reset_mid_read();                         // reset during R of burst 9
        run_pass(32'h1234, 20, -1, -1, -1, 0);
        run_pass($urandom(), 40, -1, -1, -1, 1);  // start pulsed while busy

        for (int i = 0; i < 4; i++) begin
            cn = ($urandom_range(1) == 1) ? int'($urandom_range(NUM_BURST * BURST_LEN - 1)) : -1;
            bb = ($urandom_range(2) == 0) ? int'($urandom_range(NUM_BURST - 1)) : -1;
            dr = ($urandom_range(2) == 0) ? int'($urandom_range(NUM_BURST - 1)) : -1;
            run_pass($urandom(), int'($urandom_range(60)), cn, bb, dr, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
